// File: rtl/dcache_axi_pkg.sv
// Shared constants for the L1 data-cache AXI4 master bridge:
// FSM state codes, AXI encodings and cache access-type codes.
package dcache_axi_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE = 3'd0;
   localparam state_t S_AR   = 3'd1;
   localparam state_t S_R    = 3'd2;
   localparam state_t S_AW_W = 3'd3;
   localparam state_t S_B    = 3'd4;
   localparam state_t S_DONE = 3'd5;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [7:0] FILL_LEN       = 8'd3;

   // CACHE_TYPE codes (funct3-style: bit 2 marks unsigned loads)
   localparam logic [2:0] CT_B  = 3'b000;
   localparam logic [2:0] CT_H  = 3'b001;
   localparam logic [2:0] CT_W  = 3'b010;
   localparam logic [2:0] CT_BU = 3'b100;
   localparam logic [2:0] CT_HU = 3'b101;

endpackage

// File: rtl/axi_wstrb_gen.sv
// Byte-lane strobe decode from access type and low address bits.
module axi_wstrb_gen
   import dcache_axi_pkg::*;
(
   input  logic [2:0] d_type,
   input  logic [1:0] addr_lo,
   output logic [3:0] wstrb
);

   logic is_b;
   logic is_h;
   logic is_w;

   assign is_b = (d_type == CT_B) || (d_type == CT_BU);
   assign is_h = (d_type == CT_H) || (d_type == CT_HU);
   assign is_w = (d_type == CT_W);

   always_comb begin
      wstrb = 4'b1111;
      unique case (1'b1)
         is_b:    wstrb = 4'b0001 << addr_lo;
         is_h:    wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
         is_w:    wstrb = 4'b1111;
         default: wstrb = 4'b1111;
      endcase
   end

endmodule

// File: rtl/dcache_axi_master.sv
// L1 D-cache to AXI4 master bridge: line fills, single reads, single writes.
// Optional sticky error flag axi_err_o when DCACHE_AXI_ERR_EN is defined.
module dcache_axi_master
   import dcache_axi_pkg::*;
#(
   parameter int              ADDR_W = 32,
   parameter int              DATA_W = 32,
   parameter int              ID_W   = 4,
   parameter logic [ID_W-1:0] AXI_ID = 4'h1
)(
   input  logic              clk,
   input  logic              rstn,

   input  logic              D_rreq,
   input  logic              D_wreq,
   input  logic [ADDR_W-1:0] D_addr,
   input  logic              D_write,
   input  logic [DATA_W-1:0] D_in,
   input  logic [2:0]        D_type,
   input  logic              arlenone_i,
   output logic [DATA_W-1:0] D_out,
   output logic              D_wait,

   output logic [ID_W-1:0]   ARID,
   output logic [ADDR_W-1:0] ARADDR,
   output logic [7:0]        ARLEN,
   output logic [2:0]        ARSIZE,
   output logic [1:0]        ARBURST,
   output logic              ARVALID,
   input  logic              ARREADY,

   input  logic [ID_W-1:0]   RID,
   input  logic [DATA_W-1:0] RDATA,
   input  logic [1:0]        RRESP,
   input  logic              RLAST,
   input  logic              RVALID,
   output logic              RREADY,

   output logic [ID_W-1:0]   AWID,
   output logic [ADDR_W-1:0] AWADDR,
   output logic [7:0]        AWLEN,
   output logic [2:0]        AWSIZE,
   output logic [1:0]        AWBURST,
   output logic              AWVALID,
   input  logic              AWREADY,

   output logic [DATA_W-1:0] WDATA,
   output logic [3:0]        WSTRB,
   output logic              WLAST,
   output logic              WVALID,
   input  logic              WREADY,

   input  logic [ID_W-1:0]   BID,
   input  logic [1:0]        BRESP,
   input  logic              BVALID,
   output logic              BREADY
`ifdef DCACHE_AXI_ERR_EN
   ,
   output logic              axi_err_o
`endif
);

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [2:0]        type_q;
   logic              one_q;
   logic [1:0]        beat_q;
   logic              over_q;
   logic              aw_done_q;
   logic              w_done_q;

   logic              r_hs;
   logic              r_fwd;
   logic              b_hs;
   logic              aw_hs;
   logic              w_hs;
   logic              accept;
   logic [3:0]        wstrb;
   logic              unused_ok;

   axi_wstrb_gen u_wstrb (
      .d_type  (type_q),
      .addr_lo (addr_q[1:0]),
      .wstrb   (wstrb)
   );

   assign accept = (state == S_IDLE) && (D_wreq || D_rreq);
   assign r_hs   = RVALID & RREADY;
   assign r_fwd  = r_hs & ~over_q;
   assign b_hs   = BVALID & BREADY;
   assign aw_hs  = AWVALID & AWREADY;
   assign w_hs   = WVALID & WREADY;

   assign ARID    = AXI_ID;
   assign ARADDR  = one_q ? addr_q : {addr_q[ADDR_W-1:4], 4'h0};
   assign ARLEN   = one_q ? 8'd0 : FILL_LEN;
   assign ARSIZE  = AXI_SIZE_WORD;
   assign ARBURST = AXI_BURST_INCR;
   assign ARVALID = (state == S_AR);
   assign RREADY  = (state == S_R);

   assign AWID    = AXI_ID;
   assign AWADDR  = addr_q;
   assign AWLEN   = 8'd0;
   assign AWSIZE  = AXI_SIZE_WORD;
   assign AWBURST = AXI_BURST_INCR;
   assign AWVALID = (state == S_AW_W) && !aw_done_q;

   assign WDATA   = data_q;
   assign WSTRB   = wstrb;
   assign WLAST   = 1'b1;
   assign WVALID  = (state == S_AW_W) && !w_done_q;

   assign BREADY  = (state == S_B);

   // Beats past ARLEN are still drained from the bus but hidden from the cache
   assign D_out  = r_fwd ? RDATA : '0;
   assign D_wait = ~(r_fwd | b_hs);

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (D_wreq)
               state_nx = S_AW_W;
            else if (D_rreq)
               state_nx = S_AR;
         end
         S_AR: begin
            if (ARREADY)
               state_nx = S_R;
         end
         S_R: begin
            if (r_hs && RLAST)
               state_nx = S_DONE;
         end
         S_AW_W: begin
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs))
               state_nx = S_B;
         end
         S_B: begin
            if (BVALID)
               state_nx = S_DONE;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         type_q    <= '0;
         one_q     <= 1'b0;
         beat_q    <= 2'd0;
         over_q    <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state <= state_nx;

         if (accept) begin
            addr_q <= D_addr;
            data_q <= D_in;
            type_q <= D_type;
            one_q  <= arlenone_i;
         end

         if (state == S_AR) begin
            beat_q <= 2'd0;
            over_q <= 1'b0;
         end else if (r_fwd) begin
            if (beat_q == ARLEN[1:0])
               over_q <= 1'b1;
            else
               beat_q <= beat_q + 2'd1;
         end

         if (state != S_AW_W) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
         end else begin
            if (aw_hs)
               aw_done_q <= 1'b1;
            if (w_hs)
               w_done_q <= 1'b1;
         end
      end
   end

`ifdef DCACHE_AXI_ERR_EN
   logic err_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         err_q <= 1'b0;
      else if ((r_hs && RRESP[1]) || (b_hs && BRESP[1]))
         err_q <= 1'b1;
   end

   assign axi_err_o = err_q;
`endif

   // Response codes only matter for the error flag; IDs are fixed
   assign unused_ok = &{1'b0, RID, BID, D_write, RRESP, BRESP,
                        AXI_RESP_OKAY};

endmodule

// File: tb/tb_dcache_axi_master.sv
// Randomized bench for dcache_axi_master with a transaction-level model.
// Define DCACHE_AXI_ERR_EN to also exercise the sticky error flag.
`timescale 1ns/1ps
module tb_dcache_axi_master;
   import dcache_axi_pkg::*;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        D_rreq = 0, D_wreq = 0, D_write = 0;
   logic [31:0] D_addr = 0, D_in = 0;
   logic [2:0]  D_type = 0;
   logic        arlenone_i = 0;
   logic [31:0] D_out;
   logic        D_wait;
   logic [3:0]  ARID, AWID;
   logic [31:0] ARADDR, AWADDR;
   logic [7:0]  ARLEN, AWLEN;
   logic [2:0]  ARSIZE, AWSIZE;
   logic [1:0]  ARBURST, AWBURST;
   logic        ARVALID, ARREADY = 0;
   logic [3:0]  RID = 4'h1, BID = 4'h1;
   logic [31:0] RDATA = 0;
   logic [1:0]  RRESP = 0, BRESP = 0;
   logic        RLAST = 0, RVALID = 0, RREADY;
   logic        AWVALID, AWREADY = 0;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WLAST, WVALID, WREADY = 0;
   logic        BVALID = 0, BREADY;
`ifdef DCACHE_AXI_ERR_EN
   logic        axi_err_o;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dcache_axi_master dut (
      .clk(clk), .rstn(rstn),
      .D_rreq(D_rreq), .D_wreq(D_wreq), .D_addr(D_addr),
      .D_write(D_write), .D_in(D_in), .D_type(D_type),
      .arlenone_i(arlenone_i), .D_out(D_out), .D_wait(D_wait),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
      .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
      .RVALID(RVALID), .RREADY(RREADY),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
      .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
      .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
`ifdef DCACHE_AXI_ERR_EN
      , .axi_err_o(axi_err_o)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Reference model: what the bus should see for a given request
   function automatic logic [31:0] exp_araddr(logic [31:0] a, logic one);
      return one ? a : a - (a % 16);
   endfunction

   function automatic logic [3:0] exp_strb(logic [2:0] t, logic [31:0] a);
      int off;
      off = int'(a % 4);
      if (t == CT_B || t == CT_BU)
         return 4'(1 << off);
      if (t == CT_H || t == CT_HU)
         return (off >= 2) ? 4'b1100 : 4'b0011;
      return 4'b1111;
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_arvalid"}, ARVALID, 0);
      check({tag, "_rready"}, RREADY, 0);
      check({tag, "_awvalid"}, AWVALID, 0);
      check({tag, "_wvalid"}, WVALID, 0);
      check({tag, "_bready"}, BREADY, 0);
      check({tag, "_dwait"}, D_wait, 1);
      check({tag, "_dout"}, D_out, 0);
   endtask

   // gap < 0: RVALID toggles every other cycle; abort >= 0: reset on that beat
   task automatic do_read(input logic [31:0] a, input logic one,
                          input int ar_dly, input int gap, input int extra,
                          input logic [31:0] dbase, input int abort);
      int beats;
      int total;
      int sent;
      int pulses;
      int n;
      logic hs;
      logic [31:0] d;
      beats  = one ? 1 : 4;
      total  = beats + extra;
      sent   = 0;
      pulses = 0;
      d      = 0;
      @(negedge clk);
      D_rreq = 1; D_addr = a; arlenone_i = one;
      D_type = 3'($urandom_range(7));
      n = 0; hs = 0;
      while (!hs && n < 50) begin
         @(negedge clk);
         ARREADY = (n >= ar_dly);
         if (n == 1) begin
            D_addr = $urandom;
            arlenone_i = ~one;
         end
         #1;
         if (n == 0) begin
            check("ar_lat", ARVALID, 1);
            check("arlen", ARLEN, one ? 8'd0 : 8'd3);
            check("arsize_burst", {ARSIZE, ARBURST}, 5'b010_01);
            check("arid", ARID, 4'h1);
         end
         check("ar_wait", D_wait, 1);
         hs = ARVALID & ARREADY;
         if (hs)
            check("araddr", ARADDR, exp_araddr(a, one));
         n++;
      end
      if (!hs)
         check("ar_timeout", 0, 1);
      n = 0;
      while (sent < total && n < 300) begin
         @(negedge clk);
         ARREADY = 0;
         RVALID = (gap < 0) ? (n % 2 == 0) : ($urandom_range(99) >= gap);
         if (RVALID) begin
            d = (dbase != 0) ? dbase + sent : $urandom;
            RDATA = d;
            RLAST = (sent == total - 1);
            RRESP = 2'($urandom);
         end else begin
            RLAST = 0;
         end
         #1;
         check("rready", RREADY, 1);
         if (RVALID && RREADY) begin
            if (sent < beats) begin
               check("beat_wait", D_wait, 0);
               check("beat_data", D_out, d);
               pulses++;
            end else begin
               check("extra_wait", D_wait, 1);
            end
            if (sent == abort) begin
               rstn = 0;
               #1;
               check_idle_outputs("abort");
               D_rreq = 0; RVALID = 0; RLAST = 0;
               @(negedge clk);
               rstn = 1;
               return;
            end
            sent++;
         end else begin
            check("gap_wait", D_wait, 1);
         end
         n++;
      end
      if (sent < total)
         check("r_timeout", 0, 1);
      check("pulses", pulses, beats);
      @(negedge clk);
      RVALID = 0; RLAST = 0;
      #1;
      check("done_rready", RREADY, 0);
      check("done_wait", D_wait, 1);
      check("done_arvalid", ARVALID, 0);
      @(negedge clk);
      D_rreq = 0;
      #1;
      check("idle_arvalid", ARVALID, 0);
      @(negedge clk);
      #1;
      check("no_reissue", ARVALID, 0);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] dat,
                           input logic [2:0] t, input int aw_dly,
                           input int w_dly, input int b_dly,
                           input logic [1:0] resp, input logic also_rd);
      int n;
      logic aw_ok;
      logic w_ok;
      logic done;
      @(negedge clk);
      D_wreq = 1; D_rreq = also_rd; D_addr = a; D_in = dat; D_type = t;
      D_write = 1; arlenone_i = 1'($urandom);
      n = 0; aw_ok = 0; w_ok = 0;
      while (!(aw_ok && w_ok) && n < 50) begin
         @(negedge clk);
         AWREADY = !aw_ok && (n >= aw_dly);
         WREADY  = !w_ok && (n >= w_dly);
         if (n == 1) begin
            D_addr = $urandom;
            D_in = $urandom;
            D_type = 3'($urandom);
         end
         #1;
         if (n == 0)
            check("aw_lat", AWVALID, 1);
         check("awvalid", AWVALID, !aw_ok);
         check("wvalid", WVALID, !w_ok);
         check("w_bready", BREADY, 0);
         check("w_arvalid", ARVALID, 0);
         check("w_wait", D_wait, 1);
         if (AWVALID && AWREADY) begin
            check("awaddr", AWADDR, a);
            check("awlen", AWLEN, 0);
            check("aw_size_burst", {AWSIZE, AWBURST}, 5'b010_01);
            check("awid", AWID, 4'h1);
            aw_ok = 1;
         end
         if (WVALID && WREADY) begin
            check("wstrb", WSTRB, exp_strb(t, a));
            check("wdata", WDATA, dat);
            check("wlast", WLAST, 1);
            w_ok = 1;
         end
         n++;
      end
      if (!(aw_ok && w_ok))
         check("aw_timeout", 0, 1);
      n = 0; done = 0;
      while (!done && n < 50) begin
         @(negedge clk);
         AWREADY = 0; WREADY = 0;
         BVALID = (n >= b_dly);
         BRESP = resp;
         #1;
         check("bready", BREADY, 1);
         check("b_awvalid", AWVALID, 0);
         if (BVALID) begin
            check("b_wait", D_wait, 0);
            done = 1;
         end else begin
            check("b_idle_wait", D_wait, 1);
         end
         n++;
      end
      if (!done)
         check("b_timeout", 0, 1);
      @(negedge clk);
      BVALID = 0;
      #1;
      check("wdone_bready", BREADY, 0);
      check("wdone_wait", D_wait, 1);
      check("wdone_awvalid", AWVALID, 0);
      @(negedge clk);
      D_wreq = 0; D_rreq = 0; D_write = 0;
      #1;
      check("widle_awvalid", AWVALID, 0);
      check("widle_arvalid", ARVALID, 0);
   endtask

   initial begin
      logic [2:0] types [5];
      types = '{CT_B, CT_H, CT_W, CT_BU, CT_HU};
      repeat (2) @(negedge clk);
      #1;
      check_idle_outputs("reset");
`ifdef DCACHE_AXI_ERR_EN
      check("reset_err", axi_err_o, 0);
`endif
      @(negedge clk);
      rstn = 1;

      do_read(32'h2000_0014, 0, 0, 0, 0, 32'hA0, -1);
      do_read(32'h1000_0008, 1, 0, 0, 0, 0, -1);
      do_write(32'h3000_0003, 32'h7700_0000, CT_B, 0, 0, 0, 0, 0);
      do_write(32'h3000_0102, 32'h1234_5678, CT_H, 3, 0, 1, 0, 0);
      do_write(32'h3000_0200, 32'hCAFE_F00D, CT_W, 0, 2, 0, 0, 1);
      do_read(32'h2000_0040, 0, 1, -1, 0, 0, -1);
      do_read(32'h2000_0080, 0, 0, 0, 0, 0, 1);
      do_read(32'h1000_0004, 1, 0, 0, 1, 0, -1);

`ifdef DCACHE_AXI_ERR_EN
      do_write(32'h3000_0300, 32'h1, CT_W, 0, 0, 0, 2'b10, 0);
      check("err_set", axi_err_o, 1);
      do_write(32'h3000_0304, 32'h2, CT_W, 0, 0, 0, 2'b00, 0);
      check("err_hold", axi_err_o, 1);
`endif

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(1) == 0)
            do_read($urandom, 1'($urandom), $urandom_range(3),
                    $urandom_range(60), 0, 0, -1);
         else
            do_write($urandom, $urandom, types[$urandom_range(4)],
                     $urandom_range(3), $urandom_range(3),
                     $urandom_range(3), 2'($urandom), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
